dm_mem_ctrl: RTL and testbench

//  Parametrised data memory with a valid/ready request port and a fixed, configurable access latency.

---
 rtl/dm_mem_if.sv | 25 ++
 rtl/dm_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_dm_mem_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dm_mem_if.sv
// Request/response bundle between the MEM stage and the data memory controller.
// The master drives requests; the slave returns a one-cycle response strobe.
interface dm_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_mem_ctrl.sv
// Data memory with byte/half/word access, fixed access latency and error response
// for misaligned, out-of-range or illegal-size requests. One request in flight.
module dm_mem_ctrl #(
    parameter int unsigned DEPTH   = 3072,
    parameter int unsigned LATENCY = 1
) (
    input  logic    clk,
    input  logic    reset,
    dm_mem_if.slave bus
);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  count;

    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          access;
    logic          err;
    logic [AW-1:0] word_idx;
    logic [31:0]   cur_word;
    logic [31:0]   shifted;
    logic [31:0]   wdata_rep;
    logic [31:0]   merged;
    logic [31:0]   load_data;
    logic [3:0]    byte_en;

    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;

    assign bus.req_ready = (state == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign access        = (state == BUSY) && (count == 4'd0);

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = BUSY;
            BUSY:    if (count == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All checks act on the latched request, never on the live bus.
    assign err = (lat_size == 2'b11)
              || ((lat_size == 2'b01) && lat_addr[0])
              || ((lat_size == 2'b10) && (lat_addr[1:0] != 2'b00))
              || ({2'b00, lat_addr[31:2]} >= 32'(DEPTH));

    assign word_idx = lat_addr[AW+1:2];
    assign cur_word = mem[word_idx];
    assign shifted  = cur_word >> {lat_addr[1:0], 3'b000};

    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = lat_wdata;
        load_data = 32'h0;
        merged    = cur_word;
        case (lat_size)
            2'b00: begin
                byte_en   = 4'b0001 << lat_addr[1:0];
                wdata_rep = {4{lat_wdata[7:0]}};
                load_data = lat_unsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                byte_en   = 4'b0011 << {lat_addr[1], 1'b0};
                wdata_rep = {2{lat_wdata[15:0]}};
                load_data = lat_unsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                load_data = cur_word;
            end
            default: begin
                byte_en   = 4'b0000;
                load_data = 32'h0;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = wdata_rep[8*i +: 8];
        end
    end

    // NOTE: state is updated with <= so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= 4'd0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            // NOTE: clearing every word makes this a flop array; a RAM macro cannot be reset this way.
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            rsp_valid_q <= access;
            if (accept) begin
                lat_we       <= bus.req_we;
                lat_size     <= bus.req_size;
                lat_unsigned <= bus.req_unsigned;
                lat_addr     <= bus.req_addr;
                lat_wdata    <= bus.req_wdata;
                count        <= LAT_INIT;
            end else if ((state == BUSY) && (count != 4'd0)) begin
                count <= count - 4'd1;
            end
            if (access) begin
                rsp_err_q   <= err;
                rsp_rdata_q <= (err || lat_we) ? 32'h0 : load_data;
                if (lat_we && !err) begin
                    mem[word_idx] <= merged;
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_mem_ctrl.sv
// Directed bench for dm_mem_ctrl: one instance at LATENCY=1 for data paths,
// errors and reset abort, one at LATENCY=3 for back-to-back handshake timing.
module tb_dm_mem_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] pc;
    logic [31:0] model_mem [int];

    dm_mem_if bus1();
    dm_mem_if bus3();

    dm_mem_ctrl #(.DEPTH(3072), .LATENCY(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    dm_mem_ctrl #(.DEPTH(3072), .LATENCY(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Merged word for the store trace only; results are checked against hand values.
    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [1:0] size,
                                               input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] w;
        w = old;
        case (size)
            2'b00: w[8*addr[1:0] +: 8] = wdata[7:0];
            2'b01: w[16*addr[1] +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    task automatic req1(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int          lat;
        int          widx;
        logic [31:0] old;
        @(negedge clk);
        bus1.req_valid    = 1'b1;
        bus1.req_we       = we;
        bus1.req_size     = size;
        bus1.req_unsigned = uns;
        bus1.req_addr     = addr;
        bus1.req_wdata    = wdata;
        bus1.req_pc       = pc;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        lat = 0;
        while (!bus1.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_rdata"}, bus1.rsp_rdata, exp_rdata);
        check({tag, "_err"}, {31'h0, bus1.rsp_err}, {31'h0, exp_err});
        if (we && !exp_err) begin
            widx = int'(addr[31:2]);
            old  = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
            model_mem[widx] = merge_word(old, size, addr, wdata);
            $display("@%h: *%h <= %h", bus1.req_pc, {addr[31:2], 2'b00}, model_mem[widx]);
        end
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'h0, bus1.rsp_valid}, 32'h0);
        check({tag, "_hold"}, bus1.rsp_rdata, exp_rdata);
        pc = pc + 32'd4;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pc     = 32'h0000_0100;
        reset  = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_size = 2'b00; bus1.req_unsigned = 1'b0;
        bus1.req_addr  = '0;   bus1.req_wdata = '0; bus1.req_pc = '0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_size = 2'b10; bus3.req_unsigned = 1'b0;
        bus3.req_addr  = '0;   bus3.req_wdata = '0; bus3.req_pc = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, bus1.req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, bus1.rsp_valid}, 32'h0);
        check("rst_rsp_err", {31'h0, bus1.rsp_err}, 32'h0);
        check("rst_rsp_rdata", bus1.rsp_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_ready", {31'h0, bus1.req_ready}, 32'h1);
        check("idle_ready3", {31'h0, bus3.req_ready}, 32'h1);

        // Word store and load back
        req1("t1_sw",  1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
        req1("t1_lw",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h1234_5678, 1'b0);

        // Partial stores merge; sign and zero extension
        req1("t2_sb",  1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAB, 32'h0, 1'b0);
        req1("t2_lw",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_AB78, 1'b0);
        req1("t2_lh",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000_1234, 1'b0);
        req1("t2_lbu", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000_00AB, 1'b0);
        req1("t2_lb",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFF_FFAB, 1'b0);
        req1("t2_lhs", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFF_AB78, 1'b0);
        req1("t2_lhu", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000_AB78, 1'b0);
        req1("t2_lb3", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_0012, 1'b0);
        req1("t2_sh",  1'b1, 2'b01, 1'b0, 32'h12, 32'h5555_BEEF, 32'h0, 1'b0);
        req1("t2_lw2", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF_AB78, 1'b0);
        req1("t2_lh2", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_BEEF, 1'b0);

        // Error responses leave memory untouched
        req1("t3_lw_mis",  1'b0, 2'b10, 1'b0, 32'h12,   32'h0, 32'h0, 1'b1);
        req1("t3_sh_mis",  1'b1, 2'b01, 1'b0, 32'h13,   32'h0, 32'h0, 1'b1);
        req1("t3_sz11_ld", 1'b0, 2'b11, 1'b0, 32'h10,   32'h0, 32'h0, 1'b1);
        req1("t3_sz11_st", 1'b1, 2'b11, 1'b0, 32'h10,   32'h0, 32'h0, 1'b1);
        req1("t3_lw_oor",  1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 32'h0, 1'b1);
        req1("t3_sw_oor",  1'b1, 2'b10, 1'b0, 32'h3000, 32'hDEAD_BEEF, 32'h0, 1'b1);
        req1("t3_sb_oor",  1'b1, 2'b00, 1'b0, 32'h3001, 32'h0000_0011, 32'h0, 1'b1);
        req1("t3_lw_same", 1'b0, 2'b10, 1'b0, 32'h10,   32'h0, 32'hBEEF_AB78, 1'b0);
        req1("t3_sw_last", 1'b1, 2'b10, 1'b0, 32'h2FFC, 32'hCAFE_F00D, 32'h0, 1'b0);
        req1("t3_lw_last", 1'b0, 2'b10, 1'b0, 32'h2FFC, 32'h0, 32'hCAFE_F00D, 1'b0);
        req1("t3_lw_zero", 1'b0, 2'b10, 1'b0, 32'h0,    32'h0, 32'h0, 1'b0);

        // LATENCY=3 with req_valid held high: accept every 5th cycle, response in the 4th after it
        begin
            int pulses;
            pulses = 0;
            @(negedge clk);
            bus3.req_valid = 1'b1;
            #1;
            for (int k = 0; k < 15; k++) begin
                check($sformatf("t4_ready_%0d", k), {31'h0, bus3.req_ready}, {31'h0, (k % 5) == 0});
                check($sformatf("t4_rspv_%0d", k), {31'h0, bus3.rsp_valid}, {31'h0, (k % 5) == 4});
                if (bus3.rsp_valid) pulses++;
                @(negedge clk);
                #1;
            end
            bus3.req_valid = 1'b0;
            check("t4_pulses", 32'(pulses), 32'd3);
            check("t4_rdata", bus3.rsp_rdata, 32'h0);
        end

        // Reset while BUSY aborts the store
        @(negedge clk);
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b1;
        bus1.req_size  = 2'b10;
        bus1.req_addr  = 32'h20;
        bus1.req_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_no_rsp_a", {31'h0, bus1.rsp_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_mem.delete();
        #1;
        check("t5_ready", {31'h0, bus1.req_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("t5_no_rsp_b", {31'h0, bus1.rsp_valid}, 32'h0);
        req1("t5_lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        req1("t5_lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
